// File: rtl/simple_bus_arbiter_if.sv
// Port bundle for the shared-bus arbiter: per-requester beat lanes, grant vector and the shared bus segment.
// The master modport is the arbiter's view; the slave modport is the producer/consumer side.
interface simple_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         bus_data;
  logic                      bus_valid;
  logic                      bus_ready;

  modport master (
    input  req_valid, req_data, req_last, bus_ready,
    output req_ready, gnt, bus_data, bus_valid
  );

  modport slave (
    output req_valid, req_data, req_last, bus_ready,
    input  req_ready, gnt, bus_data, bus_valid
  );
endinterface

// File: rtl/simple_bus_arbiter.sv
// Round-robin burst arbiter muxing NUM_REQ valid/ready producers onto one shared bus; one dead cycle between grants.
// Optional idle-owner forced release is enabled by defining SIMPLE_BUS_ARB_TIMEOUT_EN.
module simple_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8
) (
  input logic                  clk,
  input logic                  reset,
  simple_bus_arbiter_if.master bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner, owner_nxt;
  logic [OW-1:0] last_owner, last_owner_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;
  logic [CW-1:0] beat_inc;
  logic [OW-1:0] pick;
  logic [OW-1:0] cand;
  logic          pick_vld;
  logic          xfer;
  logic          rel;
  logic          to_hit;

  // Cyclic search starting just after the previous owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_owner) + i) % NUM_REQ);
      if (!pick_vld && bus.req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign xfer     = (state == BURST) && bus.req_valid[owner] && bus.bus_ready;
  assign beat_inc = beat_cnt + CW'(1);
  assign rel      = xfer && (bus.req_last[owner] || (beat_inc == CW'(MAX_BURST)));

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (state == BURST) && (to_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset || state != BURST || bus.req_valid[owner] || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = BURST;
          owner_nxt    = pick;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          beat_cnt_nxt = beat_inc;
        end
        if (rel || to_hit) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          beat_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Everything is gated in IDLE so stale requester data never reaches the bus.
  always_comb begin
    bus.gnt       = '0;
    bus.req_ready = '0;
    bus.bus_valid = 1'b0;
    bus.bus_data  = '0;
    if (state == BURST) begin
      bus.gnt[owner]       = 1'b1;
      bus.req_ready[owner] = bus.bus_ready;
      bus.bus_valid        = bus.req_valid[owner];
      bus.bus_data         = bus.req_data[owner*DATA_W +: DATA_W];
    end
  end
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Directed bench for simple_bus_arbiter: single burst, round-robin fairness, burst cap, backpressure, reset mid-burst.
module tb_simple_bus_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  simple_bus_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) sb ();

  simple_bus_arbiter #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .MAX_BURST(MB),
    .TIMEOUT  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] g, input logic v,
                      input logic [7:0] d, input logic [3:0] r);
    #1;
    chk({tag, ".gnt"},       32'(sb.gnt),       32'(g));
    chk({tag, ".bus_valid"}, 32'(sb.bus_valid), 32'(v));
    chk({tag, ".bus_data"},  32'(sb.bus_data),  32'(d));
    chk({tag, ".req_ready"}, 32'(sb.req_ready), 32'(r));
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    sb.req_valid[i]         = v;
    sb.req_data[i*DW +: DW] = d;
    sb.req_last[i]          = l;
  endtask

  initial begin
    reset        = 1'b1;
    sb.req_valid = '0;
    sb.req_data  = '0;
    sb.req_last  = '0;
    sb.bus_ready = 1'b0;
    repeat (2) tick();
    outs("rst", 4'b0000, 1'b0, 8'h00, 4'b0000);
    reset = 1'b0;

    // Single requester, 3-beat burst
    sb.bus_ready = 1'b1;
    set_req(2, 1'b1, 8'hA1, 1'b0);
    outs("t1_req", 4'b0000, 1'b0, 8'h00, 4'b0000);
    tick();
    outs("t1_b1", 4'b0100, 1'b1, 8'hA1, 4'b0100);
    tick(); set_req(2, 1'b1, 8'hA2, 1'b0);
    outs("t1_b2", 4'b0100, 1'b1, 8'hA2, 4'b0100);
    tick(); set_req(2, 1'b1, 8'hA3, 1'b1);
    outs("t1_b3", 4'b0100, 1'b1, 8'hA3, 4'b0100);
    tick(); set_req(2, 1'b0, 8'h00, 1'b0);
    outs("t1_idle", 4'b0000, 1'b0, 8'h00, 4'b0000);

    // Fairness from a fresh reset: 0,1,2,3,0 with a dead cycle after each grant
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
    outs("f_start", 4'b0000, 1'b0, 8'h00, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      outs($sformatf("f%0d_grant", k), 4'(1 << (k % 4)), 1'b1, 8'(8'h10 + (k % 4)),
           4'(1 << (k % 4)));
      tick();
      if (k == 4) sb.req_valid = '0;
      outs($sformatf("f%0d_dead", k), 4'b0000, 1'b0, 8'h00, 4'b0000);
    end

    // Burst cap: 6-beat burst from req 1 splits into 4 + 2
    set_req(1, 1'b1, 8'hB1, 1'b0);
    outs("c_idle", 4'b0000, 1'b0, 8'h00, 4'b0000);
    for (int b = 1; b <= 4; b++) begin
      tick(); set_req(1, 1'b1, 8'(8'hB0 + b), 1'b0);
      outs($sformatf("c_b%0d", b), 4'b0010, 1'b1, 8'(8'hB0 + b), 4'b0010);
    end
    tick(); set_req(1, 1'b1, 8'hB5, 1'b0);
    outs("c_gap", 4'b0000, 1'b0, 8'h00, 4'b0000);
    tick();
    outs("c_b5", 4'b0010, 1'b1, 8'hB5, 4'b0010);
    tick(); set_req(1, 1'b1, 8'hB6, 1'b1);
    outs("c_b6", 4'b0010, 1'b1, 8'hB6, 4'b0010);
    tick(); set_req(1, 1'b0, 8'h00, 1'b0);
    outs("c_end", 4'b0000, 1'b0, 8'h00, 4'b0000);

    // Backpressure: 3 stalled cycles on beat 2 must not advance the cap counter
    set_req(3, 1'b1, 8'hD1, 1'b0);
    outs("p_idle", 4'b0000, 1'b0, 8'h00, 4'b0000);
    tick();
    outs("p_d1", 4'b1000, 1'b1, 8'hD1, 4'b1000);
    tick(); set_req(3, 1'b1, 8'hD2, 1'b0);
    sb.bus_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      outs($sformatf("p_stall%0d", s), 4'b1000, 1'b1, 8'hD2, 4'b0000);
      tick();
    end
    sb.bus_ready = 1'b1;
    outs("p_d2", 4'b1000, 1'b1, 8'hD2, 4'b1000);
    tick(); set_req(3, 1'b1, 8'hD3, 1'b0);
    outs("p_d3", 4'b1000, 1'b1, 8'hD3, 4'b1000);
    tick(); set_req(3, 1'b1, 8'hD4, 1'b0);
    outs("p_d4", 4'b1000, 1'b1, 8'hD4, 4'b1000);
    tick(); set_req(3, 1'b1, 8'hD5, 1'b1);
    outs("p_gap", 4'b0000, 1'b0, 8'h00, 4'b0000);
    tick();
    outs("p_d5", 4'b1000, 1'b1, 8'hD5, 4'b1000);
    tick(); set_req(3, 1'b0, 8'h00, 1'b0);
    outs("p_end", 4'b0000, 1'b0, 8'h00, 4'b0000);

    // Reset mid-burst, then req 0 beats req 3
    set_req(3, 1'b1, 8'hE1, 1'b0);
    tick();
    outs("r_e1", 4'b1000, 1'b1, 8'hE1, 4'b1000);
    tick(); set_req(3, 1'b1, 8'hE2, 1'b0);
    outs("r_e2", 4'b1000, 1'b1, 8'hE2, 4'b1000);
    tick(); set_req(3, 1'b1, 8'hE3, 1'b0);
    reset = 1'b1;
    outs("r_rstcyc", 4'b1000, 1'b1, 8'hE3, 4'b1000);
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 8'hF0, 1'b1);
    outs("r_after", 4'b0000, 1'b0, 8'h00, 4'b0000);
    tick();
    outs("r_win0", 4'b0001, 1'b1, 8'hF0, 4'b0001);
    tick(); set_req(0, 1'b0, 8'h00, 1'b0);
    outs("r_dead", 4'b0000, 1'b0, 8'h00, 4'b0000);
    tick();
    outs("r_req3", 4'b1000, 1'b1, 8'hE3, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/simple_bus_arbiter.md
# simple_bus_arbiter

Round-robin arbiter that shares one simple 8-bit valid/ready bus segment among `NUM_REQ` producers. Each producer presents beats grouped into bursts. The arbiter grants one producer at a time, muxes that producer's data onto the shared bus toward the consumer, and releases the bus at end of burst or when a burst-length cap is reached. It sits between the producer instances and the shared bus interface instance in the top-level.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `DATA_W`, 8 — beat width.
- `MAX_BURST`, 4 — maximum beats per grant, ≥1.
- `TIMEOUT`, 8 — idle-owner cycles before forced release; used only with the macro.

Ports:
- `clk` in 1 — single clock, all logic on posedge.
- `reset` in 1 — synchronous, active-high.
- `req_valid` in `NUM_REQ` — per-requester beat valid.
- `req_data` in `NUM_REQ*DATA_W` — requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` in `NUM_REQ` — beat is the final beat of the requester's burst.
- `req_ready` out `NUM_REQ` — beat accepted from requester i when `req_valid[i] & req_ready[i]`.
- `gnt` out `NUM_REQ` — one-hot current owner; all zero when idle.
- `bus_data` out `DATA_W` — shared bus data.
- `bus_valid` out 1 — shared bus valid.
- `bus_ready` in 1 — consumer ready.

## Operation
- Registered state: `state` (IDLE/BURST), `owner` [$clog2(NUM_REQ)], `last_owner`, `beat_cnt` [$clog2(MAX_BURST+1)].
- IDLE:
  - If any `req_valid` is high, pick the first requester with `req_valid` high, searching cyclically from `last_owner+1`.
  - Register that index as `owner`, clear `beat_cnt`, and go to BURST.
  - If no `req_valid` is high, stay in IDLE.
- BURST outputs (combinational from registers and inputs):
  - `gnt` = onehot(`owner`).
  - `bus_valid` = `req_valid[owner]`.
  - `bus_data` = `req_data[owner]`.
  - `req_ready[owner]` = `bus_ready`; all other `req_ready` bits are 0.
- Transfer: a beat transfers when `bus_valid & bus_ready`. Each transfer increments `beat_cnt`.
- Release occurs on a transfer with `req_last[owner]` high, or on a transfer that makes `beat_cnt == MAX_BURST`. Both conditions in the same beat count as one release.
  - Next state is IDLE and `last_owner <= owner`.
- In IDLE: `gnt`, `req_ready`, and `bus_valid` are 0, and `bus_data` is 0 (gated, never passes stale data).
- Owner dropping `req_valid` mid-burst: the bus stays held and `bus_valid` is 0. No other requester is granted; the timeout option covers this case.
- A cap-forced release does not drop data. The requester's remaining beats are sent in its next grant.
- Reset values: `state`=IDLE, `owner`=0, `last_owner`=`NUM_REQ-1` (requester 0 has first priority), `beat_cnt`=0. All outputs are 0.

## Timing
- Arbitration latency: a request seen in IDLE at cycle N gives `gnt` at N+1. The first beat can transfer at N+1.
- After a release beat at cycle M, the arbiter is in IDLE at M+1 and the next grant is at M+2. There is one dead cycle between bursts.
- `req_ready` has a combinational path from `bus_ready`. No other input-to-output combinational path exists except the data and valid mux.
- Reset asserted mid-burst: the state is IDLE on the next edge. A beat transferring in the reset cycle is not counted.
- Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.

## Configuration
- Macro: `SIMPLE_BUS_ARB_TIMEOUT_EN`.
- Defined:
  - A counter [$clog2(TIMEOUT+1)] counts consecutive BURST cycles with `req_valid[owner]` low. It clears on any cycle where `req_valid[owner]` is high.
  - When the counter reaches `TIMEOUT`, the arbiter forces release the next cycle: IDLE, `last_owner <= owner`.
  - The counter resets to 0.
- Undefined: no counter is present. The owner holds the bus indefinitely until last or cap.

## Test plan
- Single requester: req 2 sends 3 beats (0xA1, 0xA2, 0xA3, last on the third), `bus_ready`=1 → `gnt`=4'b0100 one cycle after request. `bus_data` shows A1/A2/A3 on consecutive cycles, then IDLE with `gnt`=0.
- Fairness: all 4 requesters hold continuous 1-beat bursts → grant order 0,1,2,3,0, each grant followed by one idle cycle.
- Burst cap: req 1 sends a 6-beat burst with MAX_BURST=4 → 4 beats transfer, then release, then req 1 is re-granted (if alone) and beats 5–6 transfer. No beat is lost or duplicated.
- Backpressure: `bus_ready` is low for 3 cycles mid-burst → `bus_data`/`bus_valid` hold steady, `beat_cnt` does not advance, and `req_ready[owner]`=0.
- Reset mid-burst: assert `reset` after 2 beats of req 3 → next cycle all outputs are 0. After reset, req 0 wins over req 3 when both request.
- With `SIMPLE_BUS_ARB_TIMEOUT_EN`, TIMEOUT=8: the owner drops `req_valid` without last → after 8 idle cycles the bus is released and a waiting req 1 is granted 2 cycles later.
